// File: rtl/tluh_pkg.sv
// Package: tluh_pkg
// Shared TL-UH definitions for the device-side adapter: bus widths, channel
// A/D structs, opcode and param encodings, adapter FSM states and the burst
// beat-count helper.
package tluh_pkg;

    localparam int TL_AW  = 32;            // address width
    localparam int TL_DW  = 32;            // data width
    localparam int TL_DBW = TL_DW / 8;     // bytes per beat
    localparam int TL_SZW = 3;             // size field width (log2 bytes)
    localparam int TL_AIW = 8;             // source id width
    localparam int TL_DIW = 1;             // sink id width
    localparam int BEAT_W = 8;             // beat counter width (covers size up to 7)

    localparam int WORD_SIZE = $clog2(TL_DBW);
    localparam logic [TL_SZW-1:0] WORD_SIZE_SZ = TL_SZW'(WORD_SIZE);

    typedef enum logic [2:0] {
        PUT_FULL_DATA    = 3'd0,
        PUT_PARTIAL_DATA = 3'd1,
        ARITHMETIC_DATA  = 3'd2,
        LOGICAL_DATA     = 3'd3,
        GET              = 3'd4,
        INTENT           = 3'd5
    } tluh_a_op_e;

    typedef enum logic [2:0] {
        ACCESS_ACK      = 3'd0,
        ACCESS_ACK_DATA = 3'd1,
        HINT_ACK        = 3'd2
    } tluh_d_op_e;

    typedef enum logic [2:0] {
        ARITH_MIN  = 3'd0,
        ARITH_MAX  = 3'd1,
        ARITH_MINU = 3'd2,
        ARITH_MAXU = 3'd3,
        ARITH_ADD  = 3'd4
    } tluh_arith_param_e;

    typedef enum logic [2:0] {
        LOGIC_XOR  = 3'd0,
        LOGIC_OR   = 3'd1,
        LOGIC_AND  = 3'd2,
        LOGIC_SWAP = 3'd3
    } tluh_logical_param_e;

    typedef enum logic [2:0] {
        INTENT_PREFETCH_READ  = 3'd0,
        INTENT_PREFETCH_WRITE = 3'd1
    } tluh_intent_param_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_NEXT_A = 3'd3,
        ST_ALU    = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_RESP   = 3'd6
    } tluh_dev_state_e;

    // Host to device: channel A plus d_ready
    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tluh_h2d_t;

    // Device to host: a_ready plus channel D
    typedef struct packed {
        logic              a_ready;
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
    } tluh_d2h_t;

    // Number of data beats for a transfer of 2^size bytes (at least one)
    function automatic logic [BEAT_W-1:0] tluh_beats(input logic [TL_SZW-1:0] size);
        if (size <= WORD_SIZE_SZ) begin
            return BEAT_W'(1);
        end else begin
            return BEAT_W'(1) << (size - WORD_SIZE_SZ);
        end
    endfunction

endpackage

// File: rtl/tluh_atomic_alu.sv
// Module: tluh_atomic_alu
// Combinational read-modify-write datapath for TL-UH atomics.
// Ports:
//   opcode_i  - ArithmeticData or LogicalData
//   param_i   - arithmetic / logical operation select
//   old_i     - value read from the device
//   operand_i - operand from the A beat
//   new_o     - value to write back (old_i for anything unrecognised)
module tluh_atomic_alu
    import tluh_pkg::*;
(
    input  logic [2:0]       opcode_i,
    input  logic [2:0]       param_i,
    input  logic [TL_DW-1:0] old_i,
    input  logic [TL_DW-1:0] operand_i,
    output logic [TL_DW-1:0] new_o
);

    logic lt_signed;
    logic lt_unsigned;

    // Compare and select the write-back value
    always_comb begin
        lt_signed   = ($signed(old_i) < $signed(operand_i));
        lt_unsigned = (old_i < operand_i);
        new_o       = old_i;
        case (opcode_i)
            ARITHMETIC_DATA: begin
                case (param_i)
                    ARITH_MIN:  new_o = lt_signed   ? old_i : operand_i;
                    ARITH_MAX:  new_o = lt_signed   ? operand_i : old_i;
                    ARITH_MINU: new_o = lt_unsigned ? old_i : operand_i;
                    ARITH_MAXU: new_o = lt_unsigned ? operand_i : old_i;
                    ARITH_ADD:  new_o = old_i + operand_i;
                    default:    new_o = old_i;
                endcase
            end
            LOGICAL_DATA: begin
                case (param_i)
                    LOGIC_XOR:  new_o = old_i ^ operand_i;
                    LOGIC_OR:   new_o = old_i | operand_i;
                    LOGIC_AND:  new_o = old_i & operand_i;
                    LOGIC_SWAP: new_o = operand_i;
                    default:    new_o = old_i;
                endcase
            end
            default: new_o = old_i;
        endcase
    end

endmodule

// File: rtl/tluh_device_adapter.sv
// Module: tluh_device_adapter
// Device-side TL-UH endpoint. Accepts one request at a time on channel A,
// performs it on a req/gnt/rvalid memory-style port, and returns the
// AccessAck / AccessAckData / HintAck response on channel D.
// Ports:
//   clk_i, rst_ni      - clock, synchronous active-low reset
//   tl_d_i / tl_d_o    - TL-UH channel A in, channel D out (plus ready)
//   req_o, gnt_i       - device access request / accept
//   we_o, addr_o       - write enable, word-aligned address
//   wdata_o, be_o      - write data, byte enables
//   rvalid_i, rdata_i  - access completion and read data
//   err_i              - access error, qualified by rvalid_i
module tluh_device_adapter
    import tluh_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MAX_BEATS = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  tluh_h2d_t         tl_d_i,
    output tluh_d2h_t         tl_d_o,
    output logic              req_o,
    input  logic              gnt_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [TL_DW-1:0]  wdata_o,
    output logic [TL_DBW-1:0] be_o,
    input  logic              rvalid_i,
    input  logic [TL_DW-1:0]  rdata_i,
    input  logic              err_i
);

    localparam logic [TL_SZW-1:0] SIZE_LIMIT = TL_SZW'(WORD_SIZE + $clog2(MAX_BEATS));

    function automatic logic is_put(input logic [2:0] op);
        return (op == PUT_FULL_DATA) || (op == PUT_PARTIAL_DATA);
    endfunction

    function automatic logic is_atomic(input logic [2:0] op);
        return (op == ARITHMETIC_DATA) || (op == LOGICAL_DATA);
    endfunction

    tluh_dev_state_e   state_q,      state_d;
    logic [2:0]        opcode_q,     opcode_d;
    logic [2:0]        param_q,      param_d;
    logic [TL_SZW-1:0] size_q,       size_d;
    logic [TL_AIW-1:0] source_q,     source_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [TL_DBW-1:0] be_q,         be_d;
    logic [TL_DW-1:0]  wdata_q,      wdata_d;
    logic [TL_DW-1:0]  d_data_q,     d_data_d;
    logic [BEAT_W-1:0] beat_cnt_q,   beat_cnt_d;
    logic [BEAT_W-1:0] beats_m1_q,   beats_m1_d;
    logic              err_q,        err_d;
    logic              dec_err_q,    dec_err_d;
    logic              atomic_wr_q,  atomic_wr_d;
    logic              req_q,        req_d;
    logic              we_q,         we_d;
    logic              a_ready_q,    a_ready_d;
    logic              d_valid_q,    d_valid_d;
    logic              d_error_q,    d_error_d;
    logic [2:0]        d_opcode_q,   d_opcode_d;

    logic              a_fire;
    logic [TL_AW-1:0]  align_mask;
    logic              misaligned;
    logic              param_ok;
    logic              dec_err;
    logic [BEAT_W-1:0] a_beats_m1;
    logic [TL_DW-1:0]  alu_new;

    tluh_atomic_alu u_alu (
        .opcode_i  (opcode_q),
        .param_i   (param_q),
        .old_i     (d_data_q),
        .operand_i (wdata_q),
        .new_o     (alu_new)
    );

    // Decode checks on the incoming first A beat
    always_comb begin
        align_mask = (TL_AW'(1) << tl_d_i.a_size) - TL_AW'(1);
        misaligned = |(tl_d_i.a_address & align_mask);
        a_beats_m1 = tluh_beats(tl_d_i.a_size) - BEAT_W'(1);
        case (tl_d_i.a_opcode)
            PUT_FULL_DATA, PUT_PARTIAL_DATA, GET: param_ok = (tl_d_i.a_param == 3'd0);
            ARITHMETIC_DATA:                      param_ok = (tl_d_i.a_param <= 3'd4);
            LOGICAL_DATA:                         param_ok = (tl_d_i.a_param <= 3'd3);
            INTENT:                               param_ok = (tl_d_i.a_param <= 3'd1);
            default:                              param_ok = 1'b0;
        endcase
        dec_err = (tl_d_i.a_size > SIZE_LIMIT) | misaligned | ~param_ok |
                  (is_atomic(tl_d_i.a_opcode) & (tl_d_i.a_size != WORD_SIZE_SZ));
    end

    // Transaction FSM next-state and next-output computation
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        param_d     = param_q;
        size_d      = size_q;
        source_d    = source_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        d_data_d    = d_data_q;
        beat_cnt_d  = beat_cnt_q;
        beats_m1_d  = beats_m1_q;
        err_d       = err_q;
        dec_err_d   = dec_err_q;
        atomic_wr_d = atomic_wr_q;
        d_error_d   = d_error_q;
        d_opcode_d  = d_opcode_q;
        a_fire      = tl_d_i.a_valid & a_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (a_fire) begin
                    opcode_d    = tl_d_i.a_opcode;
                    param_d     = tl_d_i.a_param;
                    size_d      = tl_d_i.a_size;
                    source_d    = tl_d_i.a_source;
                    addr_d      = tl_d_i.a_address[ADDR_W-1:0];
                    wdata_d     = tl_d_i.a_data;
                    be_d        = (tl_d_i.a_opcode == GET) ? {TL_DBW{1'b1}} : tl_d_i.a_mask;
                    d_data_d    = {TL_DW{1'b0}};
                    beat_cnt_d  = {BEAT_W{1'b0}};
                    beats_m1_d  = a_beats_m1;
                    err_d       = 1'b0;
                    dec_err_d   = dec_err;
                    atomic_wr_d = 1'b0;
                    d_error_d   = dec_err;
                    case (tl_d_i.a_opcode)
                        GET, ARITHMETIC_DATA, LOGICAL_DATA: d_opcode_d = ACCESS_ACK_DATA;
                        INTENT:                             d_opcode_d = HINT_ACK;
                        default:                            d_opcode_d = ACCESS_ACK;
                    endcase
                    if (dec_err) begin
                        // A rejected Put burst still has beats in flight on A
                        if (is_put(tl_d_i.a_opcode) && (a_beats_m1 != {BEAT_W{1'b0}})) begin
                            state_d = ST_DRAIN;
                        end else begin
                            state_d = ST_RESP;
                        end
                    end else if (tl_d_i.a_opcode == INTENT) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (gnt_i) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (rvalid_i) begin
                    err_d = err_q | err_i;
                    if (opcode_q == GET) begin
                        d_data_d  = rdata_i;
                        d_error_d = err_i;
                        state_d   = ST_RESP;
                    end else if (is_put(opcode_q)) begin
                        if (beat_cnt_q == beats_m1_q) begin
                            d_error_d = err_q | err_i;
                            state_d   = ST_RESP;
                        end else begin
                            state_d = ST_NEXT_A;
                        end
                    end else if (atomic_wr_q) begin
                        d_error_d = err_q | err_i;
                        state_d   = ST_RESP;
                    end else begin
                        // Atomic read phase: a failed read skips the write
                        d_data_d = rdata_i;
                        if (err_i) begin
                            d_error_d = 1'b1;
                            state_d   = ST_RESP;
                        end else begin
                            state_d = ST_ALU;
                        end
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_NEXT_A: begin
                if (a_fire) begin
                    wdata_d    = tl_d_i.a_data;
                    be_d       = tl_d_i.a_mask;
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    addr_d     = addr_q + ADDR_W'(TL_DBW);
                    state_d    = ST_ISSUE;
                end else begin
                    state_d = ST_NEXT_A;
                end
            end
            ST_ALU: begin
                wdata_d     = alu_new;
                atomic_wr_d = 1'b1;
                state_d     = ST_ISSUE;
            end
            ST_DRAIN: begin
                if (a_fire) begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    if ((beat_cnt_q + BEAT_W'(1)) == beats_m1_q) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_RESP: begin
                if (tl_d_i.d_ready) begin
                    if ((opcode_q == GET) && !dec_err_q && (beat_cnt_q != beats_m1_q)) begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                        addr_d     = addr_q + ADDR_W'(TL_DBW);
                        state_d    = ST_ISSUE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Output flops follow the state being entered, so they line up with it
        req_d     = (state_d == ST_ISSUE);
        we_d      = (state_d == ST_ISSUE) & (is_put(opcode_d) | atomic_wr_d);
        a_ready_d = (state_d == ST_IDLE) | (state_d == ST_NEXT_A) | (state_d == ST_DRAIN);
        d_valid_d = (state_d == ST_RESP);
    end

    // State, captured request and registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            opcode_q    <= 3'd0;
            param_q     <= 3'd0;
            size_q      <= {TL_SZW{1'b0}};
            source_q    <= {TL_AIW{1'b0}};
            addr_q      <= {ADDR_W{1'b0}};
            be_q        <= {TL_DBW{1'b0}};
            wdata_q     <= {TL_DW{1'b0}};
            d_data_q    <= {TL_DW{1'b0}};
            beat_cnt_q  <= {BEAT_W{1'b0}};
            beats_m1_q  <= {BEAT_W{1'b0}};
            err_q       <= 1'b0;
            dec_err_q   <= 1'b0;
            atomic_wr_q <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            a_ready_q   <= 1'b0;
            d_valid_q   <= 1'b0;
            d_error_q   <= 1'b0;
            d_opcode_q  <= 3'd0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            param_q     <= param_d;
            size_q      <= size_d;
            source_q    <= source_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            d_data_q    <= d_data_d;
            beat_cnt_q  <= beat_cnt_d;
            beats_m1_q  <= beats_m1_d;
            err_q       <= err_d;
            dec_err_q   <= dec_err_d;
            atomic_wr_q <= atomic_wr_d;
            req_q       <= req_d;
            we_q        <= we_d;
            a_ready_q   <= a_ready_d;
            d_valid_q   <= d_valid_d;
            d_error_q   <= d_error_d;
            d_opcode_q  <= d_opcode_d;
        end
    end

    assign req_o   = req_q;
    assign we_o    = we_q;
    assign addr_o  = {addr_q[ADDR_W-1:WORD_SIZE], {WORD_SIZE{1'b0}}};
    assign wdata_o = wdata_q;
    assign be_o    = be_q;

    assign tl_d_o.a_ready  = a_ready_q;
    assign tl_d_o.d_valid  = d_valid_q;
    assign tl_d_o.d_opcode = d_opcode_q;
    assign tl_d_o.d_param  = 3'd0;
    assign tl_d_o.d_size   = size_q;
    assign tl_d_o.d_source = source_q;
    assign tl_d_o.d_sink   = {TL_DIW{1'b0}};
    assign tl_d_o.d_data   = d_data_q;
    assign tl_d_o.d_error  = d_error_q;

endmodule

// File: tb/tb_tluh_device_adapter.sv
// Testbench for tluh_device_adapter: directed TL-UH requests against a small
// reactive memory model (grant in the request cycle, rvalid one cycle later).
module tb_tluh_device_adapter;
    import tluh_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    tluh_h2d_t   h2d;
    tluh_d2h_t   d2h;
    logic        req_o, we_o, gnt_i;
    logic [31:0] addr_o, wdata_o;
    logic [3:0]  be_o;
    logic        rvalid_i = 1'b0;
    logic [31:0] rdata_i = 32'h0;
    logic        err_i = 1'b0;

    logic        gnt_en = 1'b1;
    logic        err_arm = 1'b0;
    logic        preload_en = 1'b0;
    logic [31:0] preload_addr = 32'h0;
    logic [31:0] preload_val = 32'h0;

    logic [31:0] mem [0:255];
    int          log_n = 0;
    logic        log_we    [0:63];
    logic [31:0] log_addr  [0:63];
    logic [3:0]  log_be    [0:63];
    logic [31:0] log_wdata [0:63];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign gnt_i = req_o & gnt_en;

    tluh_device_adapter #(.ADDR_W(32), .MAX_BEATS(2)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .tl_d_i  (h2d),
        .tl_d_o  (d2h),
        .req_o   (req_o),
        .gnt_i   (gnt_i),
        .we_o    (we_o),
        .addr_o  (addr_o),
        .wdata_o (wdata_o),
        .be_o    (be_o),
        .rvalid_i(rvalid_i),
        .rdata_i (rdata_i),
        .err_i   (err_i)
    );

    // Memory model: logs every granted access, answers one cycle later
    always @(posedge clk) begin
        rvalid_i <= 1'b0;
        err_i    <= 1'b0;
        if (preload_en) mem[preload_addr[9:2]] <= preload_val;
        if (req_o && gnt_i) begin
            log_we[log_n]    <= we_o;
            log_addr[log_n]  <= addr_o;
            log_be[log_n]    <= be_o;
            log_wdata[log_n] <= wdata_o;
            log_n            <= log_n + 1;
            rvalid_i         <= 1'b1;
            rdata_i          <= mem[addr_o[9:2]];
            if (we_o) begin
                for (int b = 0; b < 4; b++)
                    if (be_o[b]) mem[addr_o[9:2]][8*b +: 8] <= wdata_o[8*b +: 8];
            end else begin
                err_i <= err_arm;
            end
        end
    end

    task automatic preload(input logic [31:0] adr, input logic [31:0] val);
        @(negedge clk);
        preload_addr = adr;
        preload_val  = val;
        preload_en   = 1'b1;
        @(posedge clk);
        #1 preload_en = 1'b0;
    endtask

    task automatic send_a(input logic [2:0] op, input logic [2:0] prm, input logic [2:0] sz,
                          input logic [7:0] src, input logic [31:0] adr,
                          input logic [3:0] msk, input logic [31:0] dat);
        int n;
        @(negedge clk);
        h2d.a_opcode  = op;
        h2d.a_param   = prm;
        h2d.a_size    = sz;
        h2d.a_source  = src;
        h2d.a_address = adr;
        h2d.a_mask    = msk;
        h2d.a_data    = dat;
        h2d.a_valid   = 1'b1;
        n = 0;
        while (!d2h.a_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (d2h.a_ready !== 1'b1) begin
            errors++;
            $display("FAIL a_ready_timeout: a_ready=%b required 1 within 50 cycles", d2h.a_ready);
        end
        @(posedge clk);
        #1 h2d.a_valid = 1'b0;
    endtask

    // Waits (bounded) until d_valid is seen on a falling edge
    task automatic wait_d(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!d2h.d_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (d2h.d_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s d_valid_timeout: d_valid=%b required 1", name, d2h.d_valid);
        end
    endtask

    task automatic test_reset();
        h2d = '0;
        h2d.d_ready = 1'b1;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (d2h.a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready: got %b want 0", d2h.a_ready); end
        checks++; if (d2h.d_valid !== 1'b0) begin errors++; $display("FAIL reset_d_valid: got %b want 0", d2h.d_valid); end
        checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req_o); end
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (d2h.a_ready !== 1'b1) begin errors++; $display("FAIL idle_a_ready: got %b want 1", d2h.a_ready); end
    endtask

    task automatic test_get_single();
        int base;
        preload(32'h100, 32'hDEADBEEF);
        base = log_n;
        send_a(GET, 3'd0, 3'd2, 8'h5A, 32'h100, 4'hF, 32'h0);
        @(negedge clk);   // cycle 1
        checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL get_req_cycle1: got %b want 1", req_o); end
        checks++; if ({we_o, be_o, addr_o} !== {1'b0, 4'hF, 32'h100}) begin errors++; $display("FAIL get_req_fields: we=%b be=%h addr=%h want 0 f 00000100", we_o, be_o, addr_o); end
        @(negedge clk);   // cycle 2
        checks++; if (d2h.d_valid !== 1'b0) begin errors++; $display("FAIL get_d_early: got %b want 0", d2h.d_valid); end
        @(negedge clk);   // cycle 3
        checks++; if (d2h.d_valid !== 1'b1) begin errors++; $display("FAIL get_d_cycle3: got %b want 1", d2h.d_valid); end
        checks++; if ({d2h.d_opcode, d2h.d_data, d2h.d_error} !== {3'd1, 32'hDEADBEEF, 1'b0}) begin errors++; $display("FAIL get_d_fields: op=%0d data=%h err=%b want 1 deadbeef 0", d2h.d_opcode, d2h.d_data, d2h.d_error); end
        checks++; if ({d2h.d_source, d2h.d_size, d2h.d_sink} !== {8'h5A, 3'd2, 1'b0}) begin errors++; $display("FAIL get_d_id: src=%h size=%0d sink=%b want 5a 2 0", d2h.d_source, d2h.d_size, d2h.d_sink); end
        @(posedge clk); #1;
        checks++; if (log_n - base !== 1) begin errors++; $display("FAIL get_access_count: got %0d want 1", log_n - base); end
    endtask

    task automatic test_put_partial();
        int base;
        preload(32'h104, 32'h12345678);
        base = log_n;
        send_a(PUT_PARTIAL_DATA, 3'd0, 3'd2, 8'h21, 32'h104, 4'b0011, 32'h0000ABCD);
        wait_d("putp");
        checks++; if ({d2h.d_opcode, d2h.d_data, d2h.d_error, d2h.d_source} !== {3'd0, 32'h0, 1'b0, 8'h21}) begin errors++; $display("FAIL putp_d_fields: op=%0d data=%h err=%b src=%h want 0 0 0 21", d2h.d_opcode, d2h.d_data, d2h.d_error, d2h.d_source); end
        @(posedge clk); #1;
        checks++; if (log_n - base !== 1) begin errors++; $display("FAIL putp_access_count: got %0d want 1", log_n - base); end
        checks++; if ({log_we[base], log_be[base], log_addr[base], log_wdata[base]} !== {1'b1, 4'b0011, 32'h104, 32'h0000ABCD}) begin errors++; $display("FAIL putp_access: we=%b be=%h addr=%h wdata=%h", log_we[base], log_be[base], log_addr[base], log_wdata[base]); end
        send_a(GET, 3'd0, 3'd2, 8'h22, 32'h104, 4'hF, 32'h0);
        wait_d("putp_readback");
        checks++; if (d2h.d_data !== 32'h1234ABCD) begin errors++; $display("FAIL putp_readback: got %h want 1234abcd", d2h.d_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_put_burst();
        int base;
        base = log_n;
        send_a(PUT_FULL_DATA, 3'd0, 3'd3, 8'h30, 32'h200, 4'hF, 32'h11111111);
        send_a(PUT_FULL_DATA, 3'd0, 3'd3, 8'h30, 32'h200, 4'hF, 32'h22222222);
        wait_d("putf");
        checks++; if (log_n - base !== 2) begin errors++; $display("FAIL putf_writes_before_ack: got %0d want 2", log_n - base); end
        checks++; if ({d2h.d_opcode, d2h.d_error, d2h.d_size} !== {3'd0, 1'b0, 3'd3}) begin errors++; $display("FAIL putf_d_fields: op=%0d err=%b size=%0d want 0 0 3", d2h.d_opcode, d2h.d_error, d2h.d_size); end
        checks++; if ({log_addr[base], log_wdata[base], log_addr[base+1], log_wdata[base+1]} !== {32'h200, 32'h11111111, 32'h204, 32'h22222222}) begin errors++; $display("FAIL putf_writes: %h:%h %h:%h", log_addr[base], log_wdata[base], log_addr[base+1], log_wdata[base+1]); end
        checks++; if ({log_we[base], log_we[base+1]} !== 2'b11) begin errors++; $display("FAIL putf_we: got %b want 11", {log_we[base], log_we[base+1]}); end
        @(posedge clk); #1;
        repeat (2) begin
            @(negedge clk);
            checks++; if (d2h.d_valid !== 1'b0) begin errors++; $display("FAIL putf_extra_ack: got %b want 0", d2h.d_valid); end
        end
    endtask

    task automatic test_get_burst_backpressure();
        int base;
        base = log_n;
        h2d.d_ready = 1'b0;
        send_a(GET, 3'd0, 3'd3, 8'h40, 32'h200, 4'hF, 32'h0);
        wait_d("getb0");
        checks++; if ({d2h.d_opcode, d2h.d_data, d2h.d_error} !== {3'd1, 32'h11111111, 1'b0}) begin errors++; $display("FAIL getb_beat0: op=%0d data=%h err=%b want 1 11111111 0", d2h.d_opcode, d2h.d_data, d2h.d_error); end
        repeat (3) begin
            @(negedge clk);
            checks++; if ({d2h.d_valid, d2h.d_data} !== {1'b1, 32'h11111111}) begin errors++; $display("FAIL getb_hold: valid=%b data=%h want 1 11111111", d2h.d_valid, d2h.d_data); end
            checks++; if (log_n - base !== 1) begin errors++; $display("FAIL getb_early_read: got %0d accesses want 1", log_n - base); end
        end
        h2d.d_ready = 1'b1;
        @(posedge clk); #1;
        wait_d("getb1");
        checks++; if ({d2h.d_data, d2h.d_error} !== {32'h22222222, 1'b0}) begin errors++; $display("FAIL getb_beat1: data=%h err=%b want 22222222 0", d2h.d_data, d2h.d_error); end
        checks++; if ((log_n - base !== 2) || (log_addr[base+1] !== 32'h204)) begin errors++; $display("FAIL getb_reads: count=%0d addr1=%h want 2 00000204", log_n - base, log_addr[base+1]); end
        @(posedge clk); #1;
    endtask

    task automatic test_atomic();
        logic [2:0]  ops  [6] = '{ARITHMETIC_DATA, LOGICAL_DATA, ARITHMETIC_DATA, ARITHMETIC_DATA, LOGICAL_DATA, ARITHMETIC_DATA};
        logic [2:0]  prms [6] = '{3'd4, 3'd3, 3'd0, 3'd2, 3'd2, 3'd1};
        logic [31:0] olds [6] = '{32'hFFFFFFFF, 32'h13579BDF, 32'h00000005, 32'h00000005, 32'hF0F0F0F0, 32'h80000000};
        logic [31:0] opnd [6] = '{32'h00000002, 32'h5A5A5A5A, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h0FF00FF0, 32'h00000001};
        logic [31:0] news [6] = '{32'h00000001, 32'h5A5A5A5A, 32'hFFFFFFFE, 32'h00000005, 32'h00F000F0, 32'h00000001};
        int base;
        logic [31:0] adr;
        for (int i = 0; i < 6; i++) begin
            adr = 32'h300 + 32'(4 * i);
            preload(adr, olds[i]);
            base = log_n;
            send_a(ops[i], prms[i], 3'd2, 8'h50, adr, 4'hF, opnd[i]);
            wait_d("atomic");
            checks++; if ({d2h.d_opcode, d2h.d_data, d2h.d_error} !== {3'd1, olds[i], 1'b0}) begin errors++; $display("FAIL atomic%0d_d: op=%0d data=%h err=%b want 1 %h 0", i, d2h.d_opcode, d2h.d_data, d2h.d_error, olds[i]); end
            checks++; if ((log_n - base !== 2) || (log_we[base] !== 1'b0) || (log_we[base+1] !== 1'b1)) begin errors++; $display("FAIL atomic%0d_phases: count=%0d we=%b%b want 2 01", i, log_n - base, log_we[base], log_we[base+1]); end
            checks++; if ({log_addr[base+1], log_wdata[base+1]} !== {adr, news[i]}) begin errors++; $display("FAIL atomic%0d_write: addr=%h data=%h want %h %h", i, log_addr[base+1], log_wdata[base+1], adr, news[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_errors();
        int base;
        base = log_n;
        send_a(GET, 3'd0, 3'd2, 8'h60, 32'h102, 4'hF, 32'h0);
        wait_d("misalign");
        checks++; if ({d2h.d_opcode, d2h.d_error} !== {3'd1, 1'b1}) begin errors++; $display("FAIL misalign_d: op=%0d err=%b want 1 1", d2h.d_opcode, d2h.d_error); end
        @(posedge clk); #1;
        checks++; if (log_n - base !== 0) begin errors++; $display("FAIL misalign_access: got %0d want 0", log_n - base); end
        base = log_n;
        send_a(GET, 3'd0, 3'd4, 8'h61, 32'h0, 4'hF, 32'h0);
        wait_d("oversize");
        checks++; if ({d2h.d_error, 32'(log_n - base)} !== {1'b1, 32'd0}) begin errors++; $display("FAIL oversize: err=%b accesses=%0d want 1 0", d2h.d_error, log_n - base); end
        @(posedge clk); #1;
        base = log_n;
        send_a(INTENT, 3'd0, 3'd2, 8'h62, 32'h100, 4'hF, 32'h0);
        wait_d("intent");
        checks++; if ({d2h.d_opcode, d2h.d_error, d2h.d_data, 32'(log_n - base)} !== {3'd2, 1'b0, 32'h0, 32'd0}) begin errors++; $display("FAIL intent: op=%0d err=%b data=%h accesses=%0d want 2 0 0 0", d2h.d_opcode, d2h.d_error, d2h.d_data, log_n - base); end
        @(posedge clk); #1;
        base = log_n;
        err_arm = 1'b1;
        send_a(ARITHMETIC_DATA, 3'd4, 3'd2, 8'h63, 32'h300, 4'hF, 32'h5);
        wait_d("atomic_err");
        err_arm = 1'b0;
        checks++; if ({d2h.d_opcode, d2h.d_error} !== {3'd1, 1'b1}) begin errors++; $display("FAIL atomic_err_d: op=%0d err=%b want 1 1", d2h.d_opcode, d2h.d_error); end
        checks++; if ((log_n - base !== 1) || (log_we[base] !== 1'b0)) begin errors++; $display("FAIL atomic_err_nowrite: count=%0d we0=%b want 1 0", log_n - base, log_we[base]); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        gnt_en = 1'b0;
        send_a(GET, 3'd0, 3'd2, 8'h70, 32'h100, 4'hF, 32'h0);
        @(negedge clk);
        checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL mid_stuck_req: got %b want 1", req_o); end
        rst_ni = 1'b0;
        @(negedge clk);
        checks++; if ({req_o, d2h.d_valid, d2h.a_ready} !== 3'b000) begin errors++; $display("FAIL mid_reset_outputs: req=%b dv=%b ar=%b want 000", req_o, d2h.d_valid, d2h.a_ready); end
        rst_ni = 1'b1;
        gnt_en = 1'b1;
        send_a(GET, 3'd0, 3'd2, 8'h71, 32'h100, 4'hF, 32'h0);
        wait_d("after_reset");
        checks++; if ({d2h.d_data, d2h.d_source, d2h.d_error} !== {32'hDEADBEEF, 8'h71, 1'b0}) begin errors++; $display("FAIL after_reset_get: data=%h src=%h err=%b want deadbeef 71 0", d2h.d_data, d2h.d_source, d2h.d_error); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_get_single();
        test_put_partial();
        test_put_burst();
        test_get_burst_backpressure();
        test_atomic();
        test_errors();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
